// File: rtl/sm_init_sequencer.sv
// Start-up sequencer for the Sherman-Morrison detector: loads the signature RAM, fills the
// inverse-correlation RAM with beta*I, then enables the core for one frame.
// Optional build macro SM_SEQ_SKIP_SIG_EN adds skip_sig to reuse the previous signature.
module sm_init_sequencer #(
    parameter int unsigned NUM_BANDS              = 126,
    parameter int unsigned PIXEL_DATA_WIDTH       = 16,
    parameter int unsigned CORRELATION_DATA_WIDTH = 48,
    parameter int unsigned MAT_ADDR_WIDTH         = $clog2(NUM_BANDS * NUM_BANDS),
    parameter int unsigned SIG_ADDR_WIDTH         = $clog2(NUM_BANDS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
`ifdef SM_SEQ_SKIP_SIG_EN
    input  logic                              skip_sig,
`endif
    input  logic [CORRELATION_DATA_WIDTH-1:0] cfg_beta,
    input  logic [31:0]                       cfg_num_pixels,
    input  logic [PIXEL_DATA_WIDTH-1:0]       sig_tdata,
    input  logic                              sig_tvalid,
    output logic                              sig_tready,
    output logic                              sig_wr_en,
    output logic [SIG_ADDR_WIDTH-1:0]         sig_wr_addr,
    output logic [PIXEL_DATA_WIDTH-1:0]       sig_wr_data,
    output logic                              mat_wr_en,
    input  logic                              mat_wr_ready,
    output logic [MAT_ADDR_WIDTH-1:0]         mat_wr_addr,
    output logic [CORRELATION_DATA_WIDTH-1:0] mat_wr_data,
    output logic                              core_enable,
    input  logic                              pix_done,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadSig,
        StInitMat,
        StRun,
        StDone
    } state_e;

    localparam logic [SIG_ADDR_WIDTH-1:0] SigLast = SIG_ADDR_WIDTH'(NUM_BANDS - 1);
    localparam logic [MAT_ADDR_WIDTH-1:0] MatLast = MAT_ADDR_WIDTH'(NUM_BANDS * NUM_BANDS - 1);

    state_e                            state_q, state_d;
    logic [SIG_ADDR_WIDTH-1:0]         sig_cnt_q, sig_cnt_d;
    logic [SIG_ADDR_WIDTH-1:0]         row_q, row_d;
    logic [SIG_ADDR_WIDTH-1:0]         col_q, col_d;
    logic [MAT_ADDR_WIDTH-1:0]         mat_addr_q, mat_addr_d;
    logic [31:0]                       pix_cnt_q, pix_cnt_d;
    logic [CORRELATION_DATA_WIDTH-1:0] beta_q, beta_d;
    logic [31:0]                       num_pix_q, num_pix_d;
    logic                              core_enable_q;
    logic                              skip_load;

`ifdef SM_SEQ_SKIP_SIG_EN
    assign skip_load = skip_sig;
`else
    assign skip_load = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sig_cnt_d   = sig_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        mat_addr_d  = mat_addr_q;
        pix_cnt_d   = pix_cnt_q;
        beta_d      = beta_q;
        num_pix_d   = num_pix_q;
        sig_tready  = 1'b0;
        sig_wr_en   = 1'b0;
        sig_wr_addr = '0;
        sig_wr_data = '0;
        mat_wr_en   = 1'b0;
        mat_wr_addr = '0;
        mat_wr_data = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    beta_d     = cfg_beta;
                    num_pix_d  = cfg_num_pixels;
                    sig_cnt_d  = '0;
                    row_d      = '0;
                    col_d      = '0;
                    mat_addr_d = '0;
                    pix_cnt_d  = '0;
                    state_d    = skip_load ? StInitMat : StLoadSig;
                end
            end
            StLoadSig: begin
                sig_tready = 1'b1;
                if (sig_tvalid) begin
                    sig_wr_en   = 1'b1;
                    sig_wr_addr = sig_cnt_q;
                    sig_wr_data = sig_tdata;
                    if (sig_cnt_q == SigLast) begin
                        state_d = StInitMat;
                    end else begin
                        sig_cnt_d = sig_cnt_q + SIG_ADDR_WIDTH'(1);
                    end
                end
            end
            StInitMat: begin
                // Row/col track the linear address so the diagonal test needs no multiplier.
                mat_wr_en   = 1'b1;
                mat_wr_addr = mat_addr_q;
                mat_wr_data = (row_q == col_q) ? beta_q : '0;
                if (mat_wr_ready) begin
                    if (mat_addr_q == MatLast) begin
                        state_d = StRun;
                    end else begin
                        mat_addr_d = mat_addr_q + MAT_ADDR_WIDTH'(1);
                        if (col_q == SigLast) begin
                            col_d = '0;
                            row_d = row_q + SIG_ADDR_WIDTH'(1);
                        end else begin
                            col_d = col_q + SIG_ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            StRun: begin
                if (pix_done) begin
                    pix_cnt_d = pix_cnt_q + 32'd1;
                end
                // Leave as soon as the final pulse lands; a zero-length frame leaves at once.
                if ((pix_cnt_q == num_pix_q) || (pix_done && (pix_cnt_d == num_pix_q))) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            sig_cnt_q     <= '0;
            row_q         <= '0;
            col_q         <= '0;
            mat_addr_q    <= '0;
            pix_cnt_q     <= '0;
            beta_q        <= '0;
            num_pix_q     <= '0;
            core_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sig_cnt_q     <= sig_cnt_d;
            row_q         <= row_d;
            col_q         <= col_d;
            mat_addr_q    <= mat_addr_d;
            pix_cnt_q     <= pix_cnt_d;
            beta_q        <= beta_d;
            num_pix_q     <= num_pix_d;
            core_enable_q <= (state_d == StRun);
        end
    end

    assign core_enable = core_enable_q;
    assign busy        = (state_q == StLoadSig) || (state_q == StInitMat) || (state_q == StRun);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_sm_init_sequencer.sv
// Directed bench for sm_init_sequencer (NUM_BANDS=4) with write scoreboards for both RAM ports.
module tb_sm_init_sequencer;

    localparam int unsigned NB  = 4;
    localparam int unsigned PW  = 16;
    localparam int unsigned CW  = 48;
    localparam int unsigned MAW = 4;
    localparam int unsigned SAW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          skip_sig = 1'b0;
    logic [CW-1:0] cfg_beta = '0;
    logic [31:0]   cfg_num_pixels = '0;
    logic [PW-1:0] sig_tdata = '0;
    logic          sig_tvalid = 1'b0;
    logic          sig_tready;
    logic          sig_wr_en;
    logic [SAW-1:0] sig_wr_addr;
    logic [PW-1:0] sig_wr_data;
    logic          mat_wr_en;
    logic          mat_wr_ready = 1'b1;
    logic [MAW-1:0] mat_wr_addr;
    logic [CW-1:0] mat_wr_data;
    logic          core_enable;
    logic          pix_done = 1'b0;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int mat_cycles = 0;

    logic [SAW+PW-1:0] sig_exp_q[$];
    logic [MAW+CW-1:0] mat_exp_q[$];

    logic              held_v = 1'b0;
    logic [MAW+CW-1:0] held;

    sm_init_sequencer #(
        .NUM_BANDS              (NB),
        .PIXEL_DATA_WIDTH       (PW),
        .CORRELATION_DATA_WIDTH (CW),
        .MAT_ADDR_WIDTH         (MAW),
        .SIG_ADDR_WIDTH         (SAW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
`ifdef SM_SEQ_SKIP_SIG_EN
        .skip_sig       (skip_sig),
`endif
        .cfg_beta       (cfg_beta),
        .cfg_num_pixels (cfg_num_pixels),
        .sig_tdata      (sig_tdata),
        .sig_tvalid     (sig_tvalid),
        .sig_tready     (sig_tready),
        .sig_wr_en      (sig_wr_en),
        .sig_wr_addr    (sig_wr_addr),
        .sig_wr_data    (sig_wr_data),
        .mat_wr_en      (mat_wr_en),
        .mat_wr_ready   (mat_wr_ready),
        .mat_wr_addr    (mat_wr_addr),
        .mat_wr_data    (mat_wr_data),
        .core_enable    (core_enable),
        .pix_done       (pix_done),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sig(input int base);
        logic [SAW-1:0] a;
        logic [PW-1:0]  d;
        for (int i = 0; i < NB; i++) begin
            a = SAW'(i);
            d = PW'(base + i);
            sig_exp_q.push_back({a, d});
        end
    endtask

    // Expected beta*I image: diagonal entries sit where row == col.
    task automatic push_mat(input logic [CW-1:0] beta, input int n);
        logic [MAW-1:0] a;
        logic [CW-1:0]  d;
        for (int i = 0; i < n; i++) begin
            a = MAW'(i);
            d = ((i / NB) == (i % NB)) ? beta : '0;
            mat_exp_q.push_back({a, d});
        end
    endtask

    task automatic stream(input int base);
        for (int i = 0; i < NB; i++) begin
            sig_tvalid = 1'b1;
            sig_tdata  = PW'(base + i);
            step();
        end
        sig_tvalid = 1'b0;
    endtask

    task automatic wait_core(input string tag);
        int n = 0;
        while (core_enable !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(tag, 64'(core_enable), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Scoreboard side: every write strobe is matched against the head of its queue.
    always @(negedge clk) begin
        if (sig_wr_en === 1'b1) begin
            if (sig_exp_q.size() == 0) chk("sig_unexpected_write", 64'd1, 64'd0);
            else chk("sig_write", 64'({sig_wr_addr, sig_wr_data}), 64'(sig_exp_q.pop_front()));
        end
        if (mat_wr_en === 1'b1) begin
            mat_cycles++;
            if (held_v) chk("mat_hold_stable", 64'({mat_wr_addr, mat_wr_data}), 64'(held));
            if (mat_wr_ready) begin
                if (mat_exp_q.size() == 0) chk("mat_unexpected_write", 64'd1, 64'd0);
                else chk("mat_write", 64'({mat_wr_addr, mat_wr_data}), 64'(mat_exp_q.pop_front()));
            end
            held_v = !mat_wr_ready;
            held   = {mat_wr_addr, mat_wr_data};
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        step();
        chk("reset_outputs",
            64'({sig_tready, sig_wr_en, mat_wr_en, core_enable, busy, done}), 64'd0);
        chk("reset_data", 64'({sig_wr_addr, sig_wr_data, mat_wr_addr, mat_wr_data}), 64'd0);

        // Frame 1: gapped stream, always-ready matrix, 3 pixels with a stray pulse before RUN.
        cfg_beta       = 48'h7d0000000000;
        cfg_num_pixels = 32'd3;
        mat_wr_ready   = 1'b1;
        mat_cycles     = 0;
        push_sig(1);
        push_mat(48'h7d0000000000, 16);
        pulse_start();
        cfg_beta       = 48'h111111111111;
        cfg_num_pixels = 32'd99;
        chk("f1_busy_done", 64'({busy, done, sig_tready}), 64'b101);
        for (int i = 0; i < NB; i++) begin
            sig_tvalid = 1'b1;
            sig_tdata  = PW'(i + 1);
            step();
            sig_tvalid = 1'b0;
            if (i == 1) pix_done = 1'b1;
            if (i == NB - 1) chk("f1_tready_drop", 64'(sig_tready), 64'd0);
            step();
            pix_done = 1'b0;
        end
        wait_core("f1_core_enable");
        chk("f1_mat_cycles", 64'(mat_cycles), 64'd16);
        chk("f1_queues_empty", 64'(sig_exp_q.size() + mat_exp_q.size()), 64'd0);
        pix_done = 1'b1; step(); pix_done = 1'b0; step();
        pix_done = 1'b1; step(); pix_done = 1'b0; step();
        chk("f1_still_run", 64'({core_enable, busy, done}), 64'b110);
        pix_done = 1'b1; step(); pix_done = 1'b0;
        chk("f1_done", 64'({core_enable, busy, done}), 64'b001);
        step();
        chk("f1_done_held", 64'(done), 64'd1);

        // Frame 2: restart from DONE, ready toggling every cycle, zero-pixel frame.
        cfg_beta       = 48'h123456789abc;
        cfg_num_pixels = 32'd0;
        mat_cycles     = 0;
        push_sig(5);
        push_mat(48'h123456789abc, 16);
        pulse_start();
        chk("f2_done_drop", 64'({busy, done}), 64'b10);
        mat_wr_ready = 1'b0;
        stream(5);
        begin
            int n = 0;
            while (core_enable !== 1'b1 && n < 100) begin
                step();
                mat_wr_ready = ~mat_wr_ready;
                n++;
            end
        end
        mat_wr_ready = 1'b1;
        chk("f2_core_enable", 64'(core_enable), 64'd1);
        chk("f2_mat_cycles", 64'(mat_cycles), 64'd32);
        chk("f2_queues_empty", 64'(sig_exp_q.size() + mat_exp_q.size()), 64'd0);
        step();
        chk("f2_zero_pixel_done", 64'({core_enable, busy, done}), 64'b001);

        // Frame 3: ignored start while busy, then reset mid-INIT_MAT at address 7.
        cfg_beta       = 48'h000000000abc;
        cfg_num_pixels = 32'd1;
        push_sig(9);
        push_mat(48'h000000000abc, 8);
        pulse_start();
        start      = 1'b1;
        cfg_beta   = 48'hffffffffffff;
        sig_tvalid = 1'b1;
        sig_tdata  = PW'(9);
        step();
        start = 1'b0;
        for (int i = 1; i < NB; i++) begin
            sig_tdata = PW'(9 + i);
            step();
        end
        sig_tvalid = 1'b0;
        begin
            int n = 0;
            while (mat_wr_addr !== MAW'(7) && n < 50) begin
                step();
                n++;
            end
        end
        chk("f3_reach_addr7", 64'(mat_wr_addr), 64'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("f3_reset_outputs", 64'({mat_wr_en, core_enable, busy, done, sig_tready}), 64'd0);
        chk("f3_queues_empty", 64'(sig_exp_q.size() + mat_exp_q.size()), 64'd0);

        // Frame 4: fresh start after reset must begin again at signature address 0.
        cfg_beta = 48'h0000ff00ff00;
        push_sig(13);
        push_mat(48'h0000ff00ff00, 16);
        pulse_start();
        stream(13);
        wait_core("f4_core_enable");
        pix_done = 1'b1; step(); pix_done = 1'b0;
        chk("f4_done", 64'({core_enable, done}), 64'b01);
        chk("f4_queues_empty", 64'(sig_exp_q.size() + mat_exp_q.size()), 64'd0);

`ifdef SM_SEQ_SKIP_SIG_EN
        // Skip: matrix writes start the cycle after start, signature port stays closed.
        cfg_beta       = 48'h000000000005;
        cfg_num_pixels = 32'd0;
        skip_sig       = 1'b1;
        push_mat(48'h000000000005, 16);
        pulse_start();
        skip_sig = 1'b0;
        chk("skip_first_write", 64'({sig_tready, mat_wr_en, mat_wr_addr}), 64'({2'b01, 4'd0}));
        wait_core("skip_core_enable");
        chk("skip_queue_empty", 64'(mat_exp_q.size()), 64'd0);
        step();
        chk("skip_done", 64'(done), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
